// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-side bundle of the branch resolve unit: prediction push,
// resolve input, predictor update outputs and statistics.
interface branch_resolve_unit_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             upd_valid;
    logic             taken;
    logic             mispredict;
    logic [OCC_W-1:0] inflight;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             proto_err;

    modport master (
        output pred_valid, pred_taken, res_valid, res_taken,
        input  pred_ready, upd_valid, taken, mispredict,
               inflight, branch_cnt, miss_cnt, proto_err
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken,
        output pred_ready, upd_valid, taken, mispredict,
               inflight, branch_cnt, miss_cnt, proto_err
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Pairs in-order fetch predictions with execute outcomes, drives predictor
// updates, flushes on mispredict and holds off fetch during refill.
module branch_resolve_unit #(
    parameter int DEPTH       = 4,
    parameter int RECOVER_CYC = 3,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    branch_resolve_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int RC_W  = $clog2(RECOVER_CYC + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [DEPTH-1:0] fifo_q;
    logic [DEPTH-1:0] entry_we;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             pred_ready_q, pred_ready_d;
    logic             upd_valid_q, upd_valid_d;
    logic             taken_q, taken_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             proto_err_q, proto_err_d;

    logic empty, full, head, pop, miss, push_ok, push_en, err;

    always_comb begin
        empty   = (occ_q == '0);
        full    = (occ_q == FULL_OCC);
        head    = fifo_q[rd_ptr_q];
        pop     = bus.res_valid && !empty;
        miss    = pop && (head != bus.res_taken);
        // A full FIFO still takes a push when the same cycle frees the head.
        push_ok = bus.pred_valid && (pred_ready_q || (full && pop));
        // Wrong-path pushes in the mispredict cycle are silently discarded.
        push_en = push_ok && !miss;
        err     = (bus.pred_valid && !push_ok && !miss) || (bus.res_valid && empty);
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_we[gi] = push_en && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) fifo_q[i] <= bus.pred_taken;
        end
    end

    always_comb begin
        state_d      = state_q;
        rc_d         = rc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        upd_valid_d  = pop;
        mispredict_d = miss;
        taken_d      = pop ? bus.res_taken : taken_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        proto_err_d  = proto_err_q || err;

        if (pop && branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + 1'b1;
        if (miss && miss_cnt_q != CNT_MAX)  miss_cnt_d   = miss_cnt_q + 1'b1;

        if (miss) begin
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = ST_RECOVER;
            rc_d     = RC_W'(RECOVER_CYC);
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            occ_d = occ_q + OCC_W'(push_en) - OCC_W'(pop);
            if (state_q == ST_RECOVER) begin
                // Leaving on the 1->0 step keeps ready low for exactly RECOVER_CYC cycles.
                if (rc_q <= RC_W'(1)) begin
                    state_d = ST_IDLE;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q - 1'b1;
                end
            end else begin
                state_d = (occ_d == '0) ? ST_IDLE : ST_TRACK;
            end
        end

        pred_ready_d = (occ_d != FULL_OCC) && (state_d != ST_RECOVER);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            rc_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            pred_ready_q <= 1'b0;
            upd_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rc_q         <= rc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            pred_ready_q <= pred_ready_d;
            upd_valid_q  <= upd_valid_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.pred_ready = pred_ready_q;
    assign bus.upd_valid  = upd_valid_q;
    assign bus.taken      = taken_q;
    assign bus.mispredict = mispredict_q;
    assign bus.inflight   = occ_q;
    assign bus.branch_cnt = branch_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
    assign bus.proto_err  = proto_err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (DEPTH=4, RECOVER_CYC=3, CNT_W=4
// so counter saturation is reachable quickly).
module tb_branch_resolve_unit;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = 15;

    logic clk;
    logic reset_i;

    branch_resolve_unit_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYC(3), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_branch = 0;
    int exp_miss   = 0;

    logic       model_q[$];
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag, input int pr, input int infl, input int pe);
        check({tag, "_ready"},    32'(bus.pred_ready), 32'(pr));
        check({tag, "_inflight"}, 32'(bus.inflight),   32'(infl));
        check({tag, "_proto"},    32'(bus.proto_err),  32'(pe));
        check({tag, "_branch"},   32'(bus.branch_cnt), 32'(exp_branch));
        check({tag, "_miss"},     32'(bus.miss_cnt),   32'(exp_miss));
    endtask

    task automatic drive(input logic pv, input logic pt, input logic rv, input logic rt);
        @(negedge clk);
        bus.pred_valid = pv;
        bus.pred_taken = pt;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic t);
        model_q.push_back(t);
        drive(1'b1, t, 1'b0, 1'b0);
    endtask

    // Legal resolve of the oldest tracked prediction, optionally with a push.
    task automatic resolve(input logic rt, input logic pv, input logic pt);
        logic h, m;
        h = model_q.pop_front();
        m = (h != rt);
        exp_q.push_back({rt, m});
        if (exp_branch < CNT_SAT) exp_branch++;
        if (m && exp_miss < CNT_SAT) exp_miss++;
        if (m) model_q.delete();
        else if (pv) model_q.push_back(pt);
        drive(pv, pt, 1'b1, rt);
        check("resolve_upd_valid", 32'(bus.upd_valid), 32'd1);
    endtask

    task automatic do_reset(input logic pv, input logic rv);
        @(negedge clk);
        reset_i        = 1'b1;
        bus.pred_valid = pv;
        bus.pred_taken = 1'b1;
        bus.res_valid  = rv;
        bus.res_taken  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready",      32'(bus.pred_ready), 32'd0);
        check("rst_upd_valid",  32'(bus.upd_valid),  32'd0);
        check("rst_taken",      32'(bus.taken),      32'd0);
        check("rst_mispredict", 32'(bus.mispredict), 32'd0);
        check("rst_inflight",   32'(bus.inflight),   32'd0);
        check("rst_branch",     32'(bus.branch_cnt), 32'd0);
        check("rst_miss",       32'(bus.miss_cnt),   32'd0);
        check("rst_proto",      32'(bus.proto_err),  32'd0);
        model_q.delete();
        exp_branch = 0;
        exp_miss   = 0;
        @(negedge clk);
        reset_i        = 1'b0;
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready",    32'(bus.pred_ready), 32'd1);
        check("post_rst_inflight", 32'(bus.inflight),   32'd0);
    endtask

    // Update monitor: every pulse must match the oldest expected resolve.
    always @(negedge clk) begin
        logic [1:0] e;
        if (bus.upd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("upd_unexpected", 32'(bus.upd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("upd taken=%0d mispredict=%0d branch_cnt=%0d miss_cnt=%0d",
                         bus.taken, bus.mispredict, bus.branch_cnt, bus.miss_cnt);
                check("upd_taken",      32'(bus.taken),      32'(e[1]));
                check("upd_mispredict", 32'(bus.mispredict), 32'(e[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i        = 1'b1;
        bus.pred_valid = 1'b0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        do_reset(1'b0, 1'b0);

        // In-order correct predictions
        push(1'b1);
        check("p1_first_inflight", 32'(bus.inflight), 32'd1);
        push(1'b1);
        push(1'b0);
        check_status("p1_fill", 1, 3, 0);
        resolve(1'b1, 1'b0, 1'b0);
        resolve(1'b1, 1'b0, 1'b0);
        resolve(1'b0, 1'b0, 1'b0);
        check_status("p1_done", 1, 0, 0);
        check("p1_branch_abs", 32'(bus.branch_cnt), 32'd3);

        // Mispredict with a wrong-path push in the same cycle
        push(1'b1);
        push(1'b1);
        push(1'b1);
        resolve(1'b0, 1'b1, 1'b1);
        check("mp_pulse", 32'(bus.mispredict), 32'd1);
        check("mp_taken", 32'(bus.taken),      32'd0);
        check_status("mp", 0, 0, 0);
        idle();
        check("rec_low_2", 32'(bus.pred_ready), 32'd0);
        idle();
        check("rec_low_3", 32'(bus.pred_ready), 32'd0);
        idle();
        check("rec_high", 32'(bus.pred_ready), 32'd1);

        // Full FIFO: dropped push, then push-with-pop while full
        push(1'b1);
        push(1'b0);
        push(1'b1);
        push(1'b0);
        check_status("full", 0, 4, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_status("full_drop", 0, 4, 1);
        resolve(1'b1, 1'b1, 1'b1);
        check_status("full_swap", 0, 4, 1);
        resolve(1'b0, 1'b0, 1'b0);
        check("drain_ready", 32'(bus.pred_ready), 32'd1);
        resolve(1'b1, 1'b0, 1'b0);
        resolve(1'b0, 1'b0, 1'b0);
        resolve(1'b1, 1'b0, 1'b0);
        check_status("drained", 1, 0, 1);

        do_reset(1'b0, 1'b0);

        // Resolve on empty FIFO
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("err_empty_upd", 32'(bus.upd_valid), 32'd0);
        check_status("err_empty", 1, 0, 1);

        // Resolve during the recovery window
        push(1'b1);
        resolve(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("err_rec_upd", 32'(bus.upd_valid), 32'd0);
        check_status("err_rec", 0, 0, 1);
        idle();
        idle();
        check("err_rec_ready", 32'(bus.pred_ready), 32'd1);

        // Counter saturation: every branch mispredicted
        for (int i = 0; i < 20; i++) begin
            push(1'b1);
            resolve(1'b0, 1'b0, 1'b0);
            idle();
            idle();
            idle();
        end
        check_status("sat", 1, 0, 1);
        check("sat_branch_abs", 32'(bus.branch_cnt), 32'd15);
        check("sat_miss_abs",   32'(bus.miss_cnt),   32'd15);

        // Reset with three entries in flight, then reset inside recovery
        push(1'b1);
        push(1'b0);
        push(1'b1);
        check("mid_inflight", 32'(bus.inflight), 32'd3);
        do_reset(1'b1, 1'b1);
        push(1'b1);
        resolve(1'b0, 1'b0, 1'b0);
        check("rec_before_rst_ready", 32'(bus.pred_ready), 32'd0);
        do_reset(1'b1, 1'b1);

        idle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution-side partner of the 2-bit saturating branch predictor.
- Records each prediction issued at fetch in an in-order FIFO and pairs it with the actual outcome when the branch resolves at execute.
- Drives the predictor's `taken` update input.
- Flags mispredictions, squashes younger wrong-path entries, enforces a refill recovery window, and keeps saturating accuracy counters.

Parameters:
- DEPTH, 4, number of in-flight unresolved predictions (power of 2, ≥2).
- RECOVER_CYC, 3, cycles `pred_ready` is held low after a mispredict (≥1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- pred_valid  in  1  a prediction is issued this cycle
- pred_taken  in  1  predicted direction (1 = taken)
- pred_ready  out  1  unit can accept a prediction
- res_valid  in  1  oldest in-flight branch resolves this cycle
- res_taken  in  1  actual direction
- upd_valid  out  1  one-cycle pulse: predictor update valid
- taken  out  1  actual outcome forwarded to predictor update
- mispredict  out  1  one-cycle pulse coincident with upd_valid
- inflight  out  clog2(DEPTH)+1  FIFO occupancy
- branch_cnt  out  CNT_W  resolved branches, saturating
- miss_cnt  out  CNT_W  mispredictions, saturating
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Single clock domain. Every output is registered.
- Reset values: all outputs 0, FIFO empty, state IDLE. `pred_ready` is 1 in the cycle after reset deasserts.
- Reset asserted mid-operation wins over every other input that cycle and discards all in-flight entries.

States:
- IDLE: FIFO empty.
- TRACK: FIFO non-empty.
- RECOVER: post-mispredict refill window.

Prediction push:
- Accepted when `pred_valid` && `pred_ready`.
- `pred_ready` = not full && state != RECOVER.
- `pred_valid` while `pred_ready` = 0: the prediction is dropped and `proto_err` is set.

Resolve:
- When `res_valid` and the FIFO is non-empty: pop the head.
- On the next cycle: `upd_valid` = 1, `taken` = `res_taken`, `mispredict` = (head != `res_taken`).
- `branch_cnt` increments by 1. `miss_cnt` increments by 1 if mispredicted. Both saturate at all-ones and never wrap.
- `res_valid` with the FIFO empty, and no push in the same cycle: the resolve is ignored, `proto_err` is set, and no update pulse is produced.

Simultaneous push and resolve on a non-empty FIFO:
- Both take effect.
- Occupancy is unchanged.
- A push into a full FIFO is legal when the same cycle pops the head; `pred_ready` stays low while full.

Push and resolve on an empty FIFO:
- The resolve is an error (`proto_err` set, resolve ignored).
- The push is accepted.

Mispredict:
- The FIFO is cleared entirely (head popped, younger wrong-path entries squashed).
- Any push in the same cycle is discarded and raises no error.
- Next state is RECOVER. A down-counter is loaded with RECOVER_CYC.
- RECOVER: `pred_ready` = 0 and the counter decrements each cycle. On reaching 0, go to IDLE; `pred_ready` returns the following cycle.
- `res_valid` during RECOVER is a protocol error, since the FIFO is empty.

Transitions:
- IDLE → TRACK on push.
- TRACK → IDLE when the last entry pops correctly with no push.
- TRACK → RECOVER on mispredict from any occupancy.

Other rules:
- `inflight` reflects occupancy after the current cycle's update.
- FIFO pointers wrap modulo DEPTH.
- `proto_err` is cleared only by reset.

Test Plan:
- Reset, then push T,T,N; resolve T,T,N on successive cycles → three `upd_valid` pulses with `taken`=1,1,0, `mispredict`=0, `branch_cnt`=3, `miss_cnt`=0, `inflight` back to 0, state IDLE.
- Push 4 (DEPTH=4) → `pred_ready`=0. A fifth `pred_valid` → `proto_err`=1, `inflight` stays 4. Push plus resolve in the same full cycle → `inflight` stays 4 and the new entry is accepted.
- Push T,T,T; resolve N on the first → `mispredict`=1, `taken`=0, `inflight`=0, `miss_cnt`=1. `pred_ready` is low for exactly 3 cycles, then high. A `pred_valid` in the mispredict cycle is discarded and `proto_err` stays 0.
- `res_valid` on an empty FIFO, and `res_valid` during RECOVER → no `upd_valid`, `proto_err`=1, counters unchanged.
- With CNT_W=4, resolve 20 branches, all mispredicted → `branch_cnt`=`miss_cnt`=15, with no wrap.
- Assert reset with `inflight`=3 in RECOVER → the next cycle shows all outputs 0, and `pred_ready`=1 after deassertion.
